// File: rtl/pool_tile_sequencer_if.sv
// Stream bundle for the tile sequencer: raster input stream and raster output stream.
// master = upstream/downstream side, slave = the sequencer.
interface pool_tile_sequencer_if #(
    parameter int PIX_W = 32
);
    logic [PIX_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pool_tile_sequencer.sv
// Gathers four 8x8 blocks, feeds each to the 2x2 average-pool stage, merges the pooled
// quadrants into one 8x8 tile and streams it out. Define POOL_PIPE_EN for a 2-cycle POOL.
module pool_tile_sequencer #(
    parameter int WIDTH_IN = 8,
    parameter int PIX_W    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             soft_clr,
    pool_tile_sequencer_if.slave             bus,
    output logic [WIDTH_IN*WIDTH_IN*PIX_W-1:0] pool_pixels_in,
    output logic [1:0]                       pool_sub_block,
    input  logic [WIDTH_IN*WIDTH_IN*PIX_W-1:0] pool_pixels_out,
    output logic                             tile_done,
    output logic                             busy
);
    localparam int NPIX = WIDTH_IN * WIDTH_IN;
    localparam int CW   = $clog2(NPIX);
    localparam int HALF = WIDTH_IN / 2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
    localparam logic [1:0]    BLK_LAST = 2'd3;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_POOL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [CW-1:0]         in_cnt_r;
    logic [CW-1:0]         out_cnt_r;
    logic [1:0]            blk_idx_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [PIX_W-1:0]      in_buf_r  [NPIX];
    logic [PIX_W-1:0]      out_buf_r [NPIX];
    logic [NPIX*PIX_W-1:0] pool_src_s;
    logic                  accept_in_s;
    logic                  accept_out_s;
    logic                  pool_done_s;

    // True when raster pixel idx lies in quadrant quad (bit1 = lower half, bit0 = right half).
    function automatic logic in_quadrant(input int idx, input logic [1:0] quad);
        logic row_hi;
        logic col_hi;
        row_hi = ((idx / WIDTH_IN) >= HALF);
        col_hi = ((idx % WIDTH_IN) >= HALF);
        return (row_hi == quad[1]) && (col_hi == quad[0]);
    endfunction

    assign bus.in_ready   = in_ready_r & ~soft_clr;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_buf_r[out_cnt_r];
    assign accept_in_s    = bus.in_valid & in_ready_r & ~soft_clr;
    assign accept_out_s   = out_valid_r & bus.out_ready;
    assign tile_done      = accept_out_s & (out_cnt_r == CNT_LAST) & ~soft_clr;
    assign busy           = ~((state_r == ST_LOAD) & (in_cnt_r == CNT_ZERO) & (blk_idx_r == 2'd0));
    assign pool_sub_block = blk_idx_r;

    genvar g;
    for (g = 0; g < NPIX; g++) begin : g_flat
        assign pool_pixels_in[g*PIX_W +: PIX_W] = in_buf_r[g];
    end

`ifdef POOL_PIPE_EN
    logic                  pool_phase_r;
    logic [NPIX*PIX_W-1:0] pool_pipe_r;

    assign pool_done_s = (state_r == ST_POOL) & pool_phase_r;
    assign pool_src_s  = pool_pipe_r;

    // First POOL cycle captures the pool result; second cycle commits it to out_buf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_phase_r <= 1'b0;
            pool_pipe_r  <= {(NPIX*PIX_W){1'b0}};
        end else if (soft_clr) begin
            pool_phase_r <= 1'b0;
        end else if (state_r == ST_POOL) begin
            pool_phase_r <= ~pool_phase_r;
            if (!pool_phase_r) begin
                pool_pipe_r <= pool_pixels_out;
            end
        end else begin
            pool_phase_r <= 1'b0;
        end
    end
`else
    assign pool_done_s = (state_r == ST_POOL);
    assign pool_src_s  = pool_pixels_out;
`endif

    // Next-state selection; soft_clr overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (soft_clr) begin
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_in_s && (in_cnt_r == CNT_LAST)) begin
                        state_nxt_s = ST_POOL;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_POOL: begin
                    if (pool_done_s) begin
                        state_nxt_s = (blk_idx_r == BLK_LAST) ? ST_DRAIN : ST_LOAD;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_DRAIN: begin
                    if (accept_out_s && (out_cnt_r == CNT_LAST)) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: state_nxt_s = ST_LOAD;
            endcase
        end
    end

    // State, counters and the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            in_cnt_r    <= CNT_ZERO;
            out_cnt_r   <= CNT_ZERO;
            blk_idx_r   <= 2'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (soft_clr) begin
            state_r     <= ST_LOAD;
            in_cnt_r    <= CNT_ZERO;
            out_cnt_r   <= CNT_ZERO;
            blk_idx_r   <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_LOAD);
            out_valid_r <= (state_nxt_s == ST_DRAIN);
            if (accept_in_s) begin
                in_cnt_r <= in_cnt_r + CNT_ONE;
            end
            if (pool_done_s) begin
                blk_idx_r <= blk_idx_r + 2'd1;
            end
            if (accept_out_s) begin
                out_cnt_r <= out_cnt_r + CNT_ONE;
            end
        end
    end

    // Input block capture and quadrant merge into the output tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                in_buf_r[i]  <= {PIX_W{1'b0}};
                out_buf_r[i] <= {PIX_W{1'b0}};
            end
        end else begin
            if (accept_in_s) begin
                in_buf_r[in_cnt_r] <= bus.in_data;
            end
            if (pool_done_s && !soft_clr) begin
                for (int i = 0; i < NPIX; i++) begin
                    if (in_quadrant(i, blk_idx_r)) begin
                        out_buf_r[i] <= pool_src_s[i*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_tile_sequencer.sv
// Directed bench for pool_tile_sequencer with a behavioural 2x2 average-pool stage.
module tb_pool_tile_sequencer;
    localparam int W  = 8;
    localparam int PW = 32;
    localparam int NP = W * W;
`ifdef POOL_PIPE_EN
    localparam int EXP_PERIOD = 328;
`else
    localparam int EXP_PERIOD = 324;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           soft_clr = 1'b0;
    logic [NP*PW-1:0] pool_in;
    logic [NP*PW-1:0] pool_out;
    logic [1:0]     sub_blk;
    logic           tile_done;
    logic           busy;

    pool_tile_sequencer_if #(.PIX_W(PW)) bus ();

    pool_tile_sequencer #(.WIDTH_IN(W), .PIX_W(PW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .soft_clr        (soft_clr),
        .bus             (bus.slave),
        .pool_pixels_in  (pool_in),
        .pool_sub_block  (sub_blk),
        .pool_pixels_out (pool_out),
        .tile_done       (tile_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] avg4(input logic [NP*PW-1:0] p, input int r, input int c);
        int b;
        logic [33:0] s;
        b = 2*r*W + 2*c;
        s = 34'(p[b*PW +: PW]) + 34'(p[(b+1)*PW +: PW]) + 34'(p[(b+W)*PW +: PW]) + 34'(p[(b+W+1)*PW +: PW]);
        return s[33:2];
    endfunction

    // Pool stage stand-in: pooled 4x4 placed at the selected quadrant, junk elsewhere.
    always_comb begin
        pool_out = {NP{32'hDEADBEEF}};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                pool_out[((int'(sub_blk[1])*4 + r)*W + int'(sub_blk[0])*4 + c)*PW +: PW] = avg4(pool_in, r, c);
            end
        end
    end

    logic [31:0] blk_pix [NP];
    logic [31:0] got     [NP];
    logic [31:0] exp_pix [NP];
    int total = 0;
    int bad = 0;
    int td_cnt, td_beat, td_cycle, first_cyc, t_first, both_hi, stable_err;

    function automatic int quad_of(input int i);
        return (((i / W) >= 4) ? 2 : 0) + (((i % W) >= 4) ? 1 : 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_uniform(input logic [31:0] v);
        for (int i = 0; i < NP; i++) blk_pix[i] = v;
    endtask

    task automatic load_block(input bit toggle, input int nbeats);
        int i;
        int guard;
        bit v;
        i = 0;
        guard = 0;
        while (i < nbeats && guard < 400) begin
            @(negedge clk);
            v = toggle ? (guard % 2 == 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = blk_pix[i];
            #1;
            if (v && bus.in_ready) begin
                if (i == 0) first_cyc = cyc;
                i++;
            end
            guard++;
        end
        check("load_beats", 32'(i), 32'(nbeats));
    endtask

    task automatic load_four(input int base, input int step, input bit toggle);
        for (int k = 0; k < 4; k++) begin
            set_uniform(32'(base + step*k));
            load_block(toggle, NP);
            if (k == 0) t_first = first_cyc;
        end
        for (int i = 0; i < NP; i++) exp_pix[i] = 32'(base + step*quad_of(i));
    endtask

    task automatic drain(input bit toggle, input int nbeats);
        int j;
        int guard;
        bit r;
        bit stalled;
        logic [31:0] held;
        j = 0;
        guard = 0;
        stalled = 1'b0;
        held = 32'd0;
        while (j < nbeats && guard < 400) begin
            @(negedge clk);
            r = toggle ? (guard % 2 == 0) : 1'b1;
            bus.out_ready = r;
            #1;
            if (bus.out_valid && bus.in_ready) both_hi++;
            if (stalled && (!bus.out_valid || bus.out_data !== held)) stable_err++;
            if (tile_done) begin
                td_cnt++;
                td_beat  = j;
                td_cycle = cyc;
            end
            if (bus.out_valid && r) begin
                got[j] = bus.out_data;
                j++;
            end
            stalled = bus.out_valid && !r;
            held = bus.out_data;
            guard++;
        end
        bus.in_valid = 1'b0;
        check("drain_beats", 32'(j), 32'(nbeats));
    endtask

    task automatic compare_tile(input string tag);
        for (int i = 0; i < NP; i++) check($sformatf("%s[%0d]", tag, i), got[i], exp_pix[i]);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_bit("rst_in_ready", bus.in_ready, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_tile_done", tile_done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check("rst_sub_block", 32'(sub_blk), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check_bit("rst_pool_in_zero", (pool_in == {(NP*PW){1'b0}}), 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) #1;
        check_bit("post_rst_in_ready", bus.in_ready, 1'b1);

        // Uniform blocks, in_valid and out_ready held high throughout.
        bus.out_ready = 1'b1;
        td_cnt = 0; both_hi = 0; stable_err = 0;
        load_four(400, 400, 1'b0);
        drain(1'b0, NP);
        compare_tile("uni");
        check("uni_tile_done_cnt", 32'(td_cnt), 32'd1);
        check("uni_tile_done_beat", 32'(td_beat), 32'd63);
        check("uni_period", 32'(td_cycle - t_first + 1), 32'(EXP_PERIOD));
        check("uni_ready_valid_overlap", 32'(both_hi), 32'd0);
        @(negedge clk) #1;
        check_bit("after_tile_in_ready", bus.in_ready, 1'b1);
        check_bit("after_tile_out_valid", bus.out_valid, 1'b0);
        check_bit("after_tile_busy", busy, 1'b0);

        // Ramp in block 0 only.
        for (int i = 0; i < NP; i++) blk_pix[i] = 32'(4*i);
        load_block(1'b0, NP);
        set_uniform(32'd0);
        for (int k = 1; k < 4; k++) load_block(1'b0, NP);
        for (int i = 0; i < NP; i++)
            exp_pix[i] = ((i / W) < 4 && (i % W) < 4) ? 32'(64*(i / W) + 8*(i % W) + 18) : 32'd0;
        drain(1'b0, NP);
        check("ramp_beat0", got[0], 32'd18);
        check("ramp_beat1", got[1], 32'd26);
        check("ramp_beat8", got[8], 32'd82);
        compare_tile("ramp");

        // Toggled in_valid and out_ready.
        td_cnt = 0; stable_err = 0; both_hi = 0;
        load_four(400, 400, 1'b1);
        drain(1'b1, NP);
        compare_tile("tog");
        check("tog_stall_stable", 32'(stable_err), 32'd0);
        check("tog_tile_done_cnt", 32'(td_cnt), 32'd1);
        check("tog_ready_valid_overlap", 32'(both_hi), 32'd0);

        // soft_clr at input beat 100 (block 1, pixel 36).
        bus.out_ready = 1'b1;
        set_uniform(32'd111);
        load_block(1'b0, NP);
        set_uniform(32'd222);
        load_block(1'b0, 36);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h5A5A;
        soft_clr     = 1'b1;
        #1;
        check_bit("clr_in_ready_gated", bus.in_ready, 1'b0);
        @(negedge clk);
        soft_clr     = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_bit("clr_in_ready", bus.in_ready, 1'b1);
        check_bit("clr_busy", busy, 1'b0);
        check("clr_sub_block", 32'(sub_blk), 32'd0);
        load_four(1000, 111, 1'b0);
        drain(1'b0, NP);
        compare_tile("clr");

        // Asynchronous reset at output beat 20, then a full fresh tile.
        load_four(7, 5, 1'b0);
        drain(1'b0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
        check_bit("mid_rst_in_ready", bus.in_ready, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        td_cnt = 0;
        load_four(3000, 1, 1'b0);
        drain(1'b0, NP);
        compare_tile("post_rst");
        check("post_rst_tile_done_cnt", 32'(td_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
